axis_width_packer: RTL and testbench
====================================

# axis_width_packer

Upstream stage of the MIG-backed FIFO: packs a narrow AXI-Stream into full-width words for the FIFO input port. Lane 0 is the first beat received and lands in the least-significant bits. It provides full throughput of one input beat per cycle while the downstream is ready. It applies backpressure without losing data when the FIFO deasserts `in_tready`.

## Interface
Parameters:
- `In_Data_Size`, 32: input beat width in bits.
- `Out_Data_Size`, 128: output word width in bits. Equals `MIG_Data_Port_Size*PHY_to_UI_Rate` of the FIFO it feeds.
- Derived `RATIO = Out_Data_Size/In_Data_Size`. It must be a power of two and ≥ 2; elaboration fails otherwise.

Ports:
- `aclk`  in  1  single clock for all logic.
- `aresetn`  in  1  reset. Synchronous, active-low.
- `s_tdata`  in  In_Data_Size  input beat.
- `s_tvalid`  in  1  input valid.
- `s_tready`  out  1  input ready.
- `s_tlast`  in  1  end-of-packet marker. Used only when `PACKER_TLAST_FLUSH_EN` is defined, ignored otherwise.
- `m_tdata`  out  Out_Data_Size  packed word. Connects to the FIFO `in_tdata`.
- `m_tvalid`  out  1  word valid.
- `m_tready`  in  1  word ready.
- `words_out`  out  32  free-running count of words transferred on the m side. Wraps modulo 2^32.

## Operation
State:
- Accumulator `acc`, Out_Data_Size bits.
- Lane counter `lane`, width $clog2(RATIO), range 0..RATIO-1.
- Output register `m_tdata`/`m_tvalid`.

Rules:
- An input beat is accepted when `s_tvalid && s_tready`. An accepted beat is written to `acc[lane*In_Data_Size +: In_Data_Size]`.
- On an accepted beat with `lane < RATIO-1`, `lane` increments.
- On an accepted beat with `lane == RATIO-1`:
  - The output register loads `{s_tdata, acc[lower RATIO-1 lanes]}` and `m_tvalid` is set.
  - `lane` wraps to 0.
  - `acc` is cleared to 0.
- `s_tready = aresetn_q && !(lane == RATIO-1 && m_tvalid && !m_tready)`.
  - Here `aresetn_q` is a registered copy of `aresetn`.
  - Only the completing beat can stall. Beats for lanes 0..RATIO-2 are always accepted.
- `m_tvalid` clears on `m_tvalid && m_tready` unless a new word loads in the same cycle.
- `m_tdata` is held stable while `m_tvalid && !m_tready`, per AXIS rules.
- `words_out` increments on every m-side handshake.

Boundary conditions:
- Drain and complete in the same cycle (`m_tready = 1`, last lane accepted): the register reloads and `m_tvalid` stays 1, with no bubble.
- Output full and the downstream stalled: lanes 0..RATIO-2 keep filling `acc`; the final lane waits.
- Reset mid-operation: the partial `acc` contents and any pending output word are discarded. No partial word is ever emitted.

## Timing
- Reset values:
  - `m_tvalid = 0`, `m_tdata = 0`, `words_out = 0`.
  - `s_tready = 0` while `aresetn = 0` and during the first cycle after release. It is 1 from the second cycle after release.
  - `lane = 0`, `acc = 0`.
- Latency: the completing beat accepted at edge N gives `m_tvalid = 1` after edge N, so the word is visible in cycle N+1.
- Throughput: with `m_tready` held at 1, one output word every RATIO cycles at 100% input acceptance.
- `s_tready` depends combinationally only on registered state and `m_tready`. There is no path from `s_tvalid` to `s_tready`.

## Configuration
- Macro `PACKER_TLAST_FLUSH_EN`.
- When defined, an accepted beat with `s_tlast = 1` and `lane = k < RATIO-1`:
  - completes the word early;
  - zero-pads lanes k+1..RATIO-1;
  - sets `lane` to 0.
- In that mode, the stall condition in `s_tready` also applies when `s_tlast = 1` at any lane.
- `s_tlast` on lane RATIO-1 behaves as a normal completion.
- When undefined, `s_tlast` is unused and words complete only at full RATIO beats.

## Structure
- Package `axis_packer_pkg` holds:
  - the `RATIO` and lane-width computation functions;
  - the elaboration-time check that RATIO is a power of two and ≥ 2;
  - the `words_out` width constant (32).
- Natural sub-module: `axis_out_reg`. It is a single-entry output register with a valid/ready hold and load-while-draining. It is instantiated once for the m side.

## Test plan
All scenarios use In_Data_Size = 32 and Out_Data_Size = 128.
- Reset release: `m_tvalid = 0`, `words_out = 0`, `s_tready` low for 1 cycle after `aresetn` goes to 1, then 1.
- Streaming: 8 beats 0x0..0x7, `m_tready = 1` → words 0x00000003_00000002_00000001_00000000 and 0x00000007_00000006_00000005_00000004; `words_out = 2`; `s_tready` never drops.
- Backpressure: `m_tready = 0` after the first word → 3 more beats accepted, the 4th stalls with `s_tready = 0` and the first word held unchanged; raising `m_tready` drains it, then the next word follows with no lost or duplicated beats.
- Load-while-draining: continuous input with `m_tready = 1` → `m_tvalid` stays 1 across back-to-back word boundaries with no gap cycle.
- Reset mid-word: 2 beats 0xA, 0xB, then a 1-cycle reset, then 4 beats 0x1..0x4 → the only word emitted is 0x00000004_00000003_00000002_00000001.
- Flush (with `PACKER_TLAST_FLUSH_EN`): beats 0x11, 0x22 with `s_tlast` on the second → word 0x00000000_00000000_00000022_00000011; the next beat starts at lane 0.

Source files
------------

// File: rtl/axis_width_packer_pkg.sv
// Shared sizing helpers for the narrow-to-wide AXI-Stream packer.
// RATIO and lane-counter width are derived here so every file agrees on them.
package axis_packer_pkg;

  localparam int WORDS_OUT_W = 32;

  function automatic int calc_ratio(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  function automatic int calc_lane_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Legal only when the output is a power-of-two multiple (>= 2) of the input.
  function automatic bit ratio_valid(input int in_w, input int out_w);
    int r;
    if (in_w <= 0 || (out_w % in_w) != 0) return 1'b0;
    r = out_w / in_w;
    return (r >= 2) && ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXIS output register: holds data while stalled, reloads on the
// same edge it drains so back-to-back words leave no bubble.
module axis_out_reg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         m_tready,
  output logic         m_tvalid,
  output logic [W-1:0] m_tdata
);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else if (load) begin
      m_tvalid <= 1'b1;
      m_tdata  <= load_dat;
    end else if (m_tvalid && m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_width_packer.sv
// Packs In_Data_Size beats (lane 0 in the LSBs) into Out_Data_Size words.
// Optional PACKER_TLAST_FLUSH_EN: s_tlast completes a partial word, zero-padded.
module axis_width_packer
  import axis_packer_pkg::*;
#(
  parameter int In_Data_Size  = 32,
  parameter int Out_Data_Size = 128
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [In_Data_Size-1:0]  s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  output logic [Out_Data_Size-1:0] m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [WORDS_OUT_W-1:0]   words_out
);

  localparam int RATIO  = calc_ratio(In_Data_Size, Out_Data_Size);
  localparam int LANE_W = calc_lane_w(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  if (!ratio_valid(In_Data_Size, Out_Data_Size)) begin : g_bad_ratio
    $error("axis_width_packer: Out_Data_Size/In_Data_Size must be a power of two >= 2");
  end

  logic                     aresetn_q;
  logic [LANE_W-1:0]        lane;
  logic [Out_Data_Size-1:0] acc;
  logic [Out_Data_Size-1:0] word;
  logic                     ends_word;
  logic                     accept;
  logic                     complete;

`ifdef PACKER_TLAST_FLUSH_EN
  assign ends_word = (lane == LAST_LANE) || s_tlast;
`else
  logic unused_tlast;
  assign unused_tlast = s_tlast;
  assign ends_word    = (lane == LAST_LANE);
`endif

  // Only a word-completing beat can stall; it waits for the output slot to free.
  assign s_tready = aresetn && aresetn_q && !(ends_word && m_tvalid && !m_tready);
  assign accept   = s_tvalid && s_tready;
  assign complete = accept && ends_word;

  // Lanes above the current one are still zero in acc, which gives the flush padding.
  always_comb begin
    word = acc;
    word[int'(lane)*In_Data_Size +: In_Data_Size] = s_tdata;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aresetn_q <= 1'b0;
      lane      <= '0;
      acc       <= '0;
      words_out <= '0;
    end else begin
      aresetn_q <= 1'b1;
      if (complete) begin
        lane <= '0;
        acc  <= '0;
      end else if (accept) begin
        lane <= lane + LANE_W'(1);
        acc[int'(lane)*In_Data_Size +: In_Data_Size] <= s_tdata;
      end
      if (m_tvalid && m_tready) words_out <= words_out + WORDS_OUT_W'(1);
    end
  end

  axis_out_reg #(.W(Out_Data_Size)) u_out_reg (
    .clk      (aclk),
    .aresetn  (aresetn),
    .load     (complete),
    .load_dat (word),
    .m_tready (m_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata)
  );

endmodule

// File: tb/tb_axis_width_packer.sv
// Scoreboard bench for axis_width_packer (32 -> 128): stimulus pushes expected
// words, a negedge monitor pops and compares every m-side handshake.
module tb_axis_width_packer;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [31:0]  s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [127:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic [31:0]  words_out;

  logic [127:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int stalls = 0;
  bit mon_en = 1'b0;

  always #5 aclk = ~aclk;

  axis_width_packer #(.In_Data_Size(32), .Out_Data_Size(128)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .words_out (words_out)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge aclk) begin
    if (mon_en && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %h expected none", m_tdata);
      end else begin
        chk("word", m_tdata, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was taken.
  task automatic beat(input logic [31:0] d, input logic l);
    int t;
    logic ok;
    t = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      ok = s_tready;
      step();
      if (ok) break;
      stalls++;
      t++;
      if (t > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_timeout: got s_tready=0 for %0d cycles expected accept", t);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  localparam logic [127:0] W_A = 128'h00000013_00000012_00000011_00000010;
  localparam logic [127:0] W_B = 128'h00000017_00000016_00000015_00000014;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    repeat (3) step();

    // Reset state and release timing of s_tready.
    @(negedge aclk);
    chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
    chk("rst_m_tdata", m_tdata, 128'd0);
    chk("rst_words_out", 128'(words_out), 128'd0);
    chk("rst_s_tready", 128'(s_tready), 128'd0);
    step();
    aresetn = 1'b1;
    mon_en  = 1'b1;
    @(negedge aclk);
    chk("rel_cycle1_s_tready", 128'(s_tready), 128'd0);
    step();
    @(negedge aclk);
    chk("rel_cycle2_s_tready", 128'(s_tready), 128'd1);
    step();

    // Streaming at full rate.
    exp_q.push_back(128'h00000003_00000002_00000001_00000000);
    exp_q.push_back(128'h00000007_00000006_00000005_00000004);
    stalls = 0;
    for (int i = 0; i < 8; i++) beat(32'(i), 1'b0);
    chk("stream_stalls", 128'(stalls), 128'd0);
    step();
    step();
    chk("stream_words_out", 128'(words_out), 128'd2);

    // Backpressure: word A held, three lanes still fill, the completing beat waits.
    exp_q.push_back(W_A);
    exp_q.push_back(W_B);
    for (int i = 0; i < 4; i++) beat(32'h10 + 32'(i), 1'b0);
    m_tready = 1'b0;
    stalls = 0;
    for (int i = 4; i < 7; i++) beat(32'h10 + 32'(i), 1'b0);
    chk("bp_fill_stalls", 128'(stalls), 128'd0);
    s_tdata  = 32'h17;
    s_tvalid = 1'b1;
    @(negedge aclk);
    chk("bp_s_tready", 128'(s_tready), 128'd0);
    chk("bp_m_tvalid", 128'(m_tvalid), 128'd1);
    chk("bp_hold_1", m_tdata, W_A);
    step();
    @(negedge aclk);
    chk("bp_hold_2", m_tdata, W_A);
    chk("bp_s_tready_2", 128'(s_tready), 128'd0);
    step();
    m_tready = 1'b1;
    @(negedge aclk);
    chk("drain_s_tready", 128'(s_tready), 128'd1);
    step();
    s_tvalid = 1'b0;
    // Drain and reload on the same edge: valid must not drop.
    @(negedge aclk);
    chk("ldrain_m_tvalid", 128'(m_tvalid), 128'd1);
    chk("ldrain_m_tdata", m_tdata, W_B);
    step();
    step();
    chk("bp_words_out", 128'(words_out), 128'd4);

    // Reset mid-word: partial lanes 0xA, 0xB must vanish.
    beat(32'hA, 1'b0);
    beat(32'hB, 1'b0);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    exp_q.push_back(128'h00000004_00000003_00000002_00000001);
    for (int i = 1; i <= 4; i++) beat(32'(i), 1'b0);
    step();
    step();
    chk("mid_rst_words_out", 128'(words_out), 128'd1);

`ifdef PACKER_TLAST_FLUSH_EN
    exp_q.push_back(128'h00000000_00000000_00000022_00000011);
    exp_q.push_back(128'h00000034_00000033_00000032_00000031);
    beat(32'h11, 1'b0);
    beat(32'h22, 1'b1);
    for (int i = 1; i <= 4; i++) beat(32'h30 + 32'(i), 1'b0);
    step();
    step();
    chk("flush_words_out", 128'(words_out), 128'd3);
`endif

    repeat (4) step();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
